// File: rtl/conv_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_feeder
// Purpose  : Raster pixel stream -> 5x5 sliding window, emitted as 25
//            parallel lanes (lane k = r*5+c, r=0 oldest row, c=0 oldest col).
//            Four line buffers hold the previous rows; one window is
//            produced per accepted pixel once the window is fully in-frame.
// Revision : 1.0  initial release
// ============================================================================
module conv_window_feeder #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_sof,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [25*DATA_W-1:0]  win_data,
  output logic                  frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int LANES = 25;

  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] C_COL_WIN  = COL_W'(4);
  localparam logic [ROW_W-1:0] C_ROW_WIN  = ROW_W'(4);

  // Raster position of the next expected pixel
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  // Line buffers: r_lb[0] holds the previous row, r_lb[3] the oldest
  logic [DATA_W-1:0] r_lb [4][IMG_W];

  // Sliding window storage and its next value
  logic [DATA_W-1:0] r_win      [LANES];
  logic [DATA_W-1:0] w_win_next [LANES];
  logic [DATA_W-1:0] w_colvec   [5];
  logic [LANES*DATA_W-1:0] w_win_flat;

  logic                     r_out_valid;
  logic [LANES*DATA_W-1:0]  r_win_data;
  logic                     r_frame_done;

  logic             w_in_hs;
  logic             w_out_hs;
  logic             w_win_load;
  logic             w_last_pix;
  logic [COL_W-1:0] w_cur_col;
  logic [ROW_W-1:0] w_cur_row;
  logic [COL_W-1:0] w_nxt_col;
  logic [ROW_W-1:0] w_nxt_row;

  // The pipeline only stalls while a finished window is still unaccepted
  assign in_ready = !r_out_valid || out_ready;
  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = r_out_valid && out_ready;

  // A start-of-frame pixel is always (0,0), overriding the counters
  assign w_cur_col  = in_sof ? '0 : r_col;
  assign w_cur_row  = in_sof ? '0 : r_row;
  assign w_win_load = (w_cur_row >= C_ROW_WIN) && (w_cur_col >= C_COL_WIN);
  assign w_last_pix = (w_cur_row == C_ROW_LAST) && (w_cur_col == C_COL_LAST);

  // Next raster position with column and frame wrap
  always_comb begin
    w_nxt_col = w_cur_col + 1'b1;
    w_nxt_row = w_cur_row;
    if (w_cur_col == C_COL_LAST) begin
      w_nxt_col = '0;
      w_nxt_row = (w_cur_row == C_ROW_LAST) ? '0 : w_cur_row + 1'b1;
    end
  end

  // New column (oldest row first) and the window shifted by one column
  always_comb begin
    w_colvec[0] = r_lb[3][w_cur_col];
    w_colvec[1] = r_lb[2][w_cur_col];
    w_colvec[2] = r_lb[1][w_cur_col];
    w_colvec[3] = r_lb[0][w_cur_col];
    w_colvec[4] = in_data;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (c < 4) begin
          w_win_next[r*5+c] = r_win[r*5+c+1];
        end else begin
          w_win_next[r*5+c] = w_colvec[r];
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_pack
      assign w_win_flat[k*DATA_W +: DATA_W] = w_win_next[k];
    end
  endgenerate

  // Position counters advance on each accepted pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_in_hs) begin
      r_col <= w_nxt_col;
      r_row <= w_nxt_row;
    end
  end

  // Line buffers ripple one row older at the current column (read before write)
  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_lb[3][w_cur_col] <= r_lb[2][w_cur_col];
      r_lb[2][w_cur_col] <= r_lb[1][w_cur_col];
      r_lb[1][w_cur_col] <= r_lb[0][w_cur_col];
      r_lb[0][w_cur_col] <= in_data;
    end
  end

  // Window shifts on every accepted pixel, including across row wrap
  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      for (int k = 0; k < LANES; k++) begin
        r_win[k] <= w_win_next[k];
      end
    end
  end

  // Output holding register: load a fully in-frame window, else drain on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_win_data  <= '0;
    end else if (w_in_hs && w_win_load) begin
      r_out_valid <= 1'b1;
      r_win_data  <= w_win_flat;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  // One-cycle pulse after the last pixel of a frame is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_in_hs && w_last_pix;
    end
  end

  assign out_valid  = r_out_valid;
  assign win_data   = r_win_data;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_feeder
// Purpose  : Directed self-checking bench for conv_window_feeder, using a
//            6x6 instance for the small scenarios and a 28x28 instance for
//            the random-bubble full-frame run.
// Revision : 1.0  initial release
// ============================================================================
module tb_conv_window_feeder;

  localparam int DW = 16;
  localparam int WW = 25 * DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 6x6 instance
  logic          in_valid, in_ready, in_sof, out_valid, out_ready, frame_done;
  logic [DW-1:0] in_data;
  logic [WW-1:0] win_data;

  // 28x28 instance
  logic          b_in_valid, b_in_ready, b_in_sof, b_out_valid, b_out_ready, b_frame_done;
  logic [DW-1:0] b_in_data;
  logic [WW-1:0] b_win_data;

  conv_window_feeder #(.DATA_W(DW), .IMG_W(6), .IMG_H(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .out_valid(out_valid),
    .out_ready(out_ready), .win_data(win_data), .frame_done(frame_done)
  );

  conv_window_feeder #(.DATA_W(DW), .IMG_W(28), .IMG_H(28)) dut28 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sof(b_in_sof), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .win_data(b_win_data), .frame_done(b_frame_done)
  );

  int tests = 0;
  int fails = 0;

  logic [WW-1:0] winq[$];
  logic [WW-1:0] b_winq[$];
  int fd_cnt = 0;
  int fd_at  = -1;
  logic [DW-1:0] pix28 [784];

  // Record accepted windows and frame_done pulses mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) winq.push_back(win_data);
      if (frame_done) begin
        fd_cnt++;
        fd_at = winq.size();
      end
      if (b_out_valid && b_out_ready) b_winq.push_back(b_win_data);
    end
  end

  function automatic logic [DW-1:0] lane(input logic [WW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  // Expected 6x6 window j where pixel(r,c) = base + r*6 + c
  function automatic logic [WW-1:0] exp6(input int base, input int j);
    logic [WW-1:0] v;
    int wr, wc;
    wr = 4 + j / 2;
    wc = 4 + j % 2;
    for (int k = 0; k < 25; k++)
      v[k*DW +: DW] = DW'(base + (wr - 4 + k / 5) * 6 + (wc - 4 + k % 5));
    return v;
  endfunction

  function automatic logic [WW-1:0] exp28(input int j);
    logic [WW-1:0] v;
    int wr, wc;
    wr = 4 + j / 24;
    wc = 4 + j % 24;
    for (int k = 0; k < 25; k++)
      v[k*DW +: DW] = pix28[(wr - 4 + k / 5) * 28 + (wc - 4 + k % 5)];
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_sof = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    winq.delete();
    b_winq.delete();
    fd_cnt = 0;
    fd_at = -1;
  endtask

  // Feed `count` consecutive pixels of a 6x6 frame into dut6 (no checks)
  task automatic drive6(input int base, input int first, input int count, input bit sof_first);
    int idx, n, guard;
    idx = first; n = 0; guard = 0;
    while (n < count && guard < 2000) begin
      in_valid = 1'b1;
      in_sof   = sof_first && (n == 0);
      in_data  = DW'(base + (idx % 36));
      #2;
      if (in_ready) begin
        n++;
        idx++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (n < count) begin
      tests++; fails++;
      $display("FAIL drive6_timeout accepted %0d required %0d", n, count);
    end
  endtask

  task automatic check_frame6(input string tag, input int base, input int first_q);
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (winq.size() <= first_q + j) begin
        fails++;
        $display("FAIL %s_w%0d missing window (queue size %0d)", tag, j, winq.size());
      end else if (winq[first_q + j] !== exp6(base, j)) begin
        fails++;
        $display("FAIL %s_w%0d got %h exp %h", tag, j, winq[first_q + j], exp6(base, j));
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    tests++; if (win_data !== '0) begin fails++; $display("FAIL rst_win_data got %h exp 0", win_data); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_frame_done got %b exp 0", frame_done); end
    tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL rst_b_out_valid got %b exp 0", b_out_valid); end
  endtask

  task automatic test_basic();
    do_reset();
    drive6(0, 0, 36, 1'b1);
    idle(3);
    tests++; if (winq.size() != 4) begin fails++; $display("FAIL t1_count got %0d exp 4", winq.size()); end
    if (winq.size() >= 4) begin
      tests++; if (lane(winq[0], 0)  !== 16'd0)  begin fails++; $display("FAIL t1_w0_l0 got %0d exp 0",   lane(winq[0], 0));  end
      tests++; if (lane(winq[0], 12) !== 16'd14) begin fails++; $display("FAIL t1_w0_l12 got %0d exp 14", lane(winq[0], 12)); end
      tests++; if (lane(winq[0], 24) !== 16'd28) begin fails++; $display("FAIL t1_w0_l24 got %0d exp 28", lane(winq[0], 24)); end
      tests++; if (lane(winq[0], 4)  !== 16'd4)  begin fails++; $display("FAIL t1_w0_l4 got %0d exp 4",   lane(winq[0], 4));  end
      tests++; if (lane(winq[0], 20) !== 16'd24) begin fails++; $display("FAIL t1_w0_l20 got %0d exp 24", lane(winq[0], 20)); end
      tests++; if (lane(winq[3], 0)  !== 16'd7)  begin fails++; $display("FAIL t1_w3_l0 got %0d exp 7",   lane(winq[3], 0));  end
      tests++; if (lane(winq[3], 24) !== 16'd35) begin fails++; $display("FAIL t1_w3_l24 got %0d exp 35", lane(winq[3], 24)); end
    end
    check_frame6("t1", 0, 0);
    tests++; if (fd_cnt != 1) begin fails++; $display("FAIL t1_fd_count got %0d exp 1", fd_cnt); end
    tests++; if (fd_at != 4) begin fails++; $display("FAIL t1_fd_with_w3 got %0d exp 4", fd_at); end
  endtask

  task automatic test_backpressure();
    int idx, stall_left, chk_next, guard;
    bit stalled;
    logic [WW-1:0] w0;
    do_reset();
    w0 = exp6(0, 0);
    idx = 0; stall_left = 0; chk_next = 0; guard = 0; stalled = 1'b0;
    while (idx < 36 && guard < 200) begin
      if (chk_next == 1) begin
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t2_w1_valid got %b exp 1", out_valid); end
        tests++; if (lane(win_data, 0) !== 16'd1) begin fails++; $display("FAIL t2_w1_l0 got %0d exp 1", lane(win_data, 0)); end
        tests++; if (lane(win_data, 24) !== 16'd29) begin fails++; $display("FAIL t2_w1_l24 got %0d exp 29", lane(win_data, 24)); end
      end
      if (chk_next > 0) chk_next--;
      if (!stalled && out_valid) begin
        stalled = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      in_valid  = 1'b1;
      in_sof    = (idx == 0);
      in_data   = DW'(idx);
      #2;
      if (stall_left > 0) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL t2_stall_in_ready got %b exp 0", in_ready); end
        tests++; if (win_data !== w0) begin fails++; $display("FAIL t2_stall_hold got %h exp %h", win_data, w0); end
        stall_left--;
        if (stall_left == 0) chk_next = 2;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    tests++; if (idx != 36) begin fails++; $display("FAIL t2_timeout accepted %0d exp 36", idx); end
    idle(3);
    tests++; if (winq.size() != 4) begin fails++; $display("FAIL t2_count got %0d exp 4", winq.size()); end
    check_frame6("t2", 0, 0);
  endtask

  task automatic test_bubbles28();
    int idx, guard, n;
    do_reset();
    for (int i = 0; i < 784; i++) pix28[i] = DW'($urandom_range(0, 65535));
    idx = 0; guard = 0;
    while (idx < 784 && guard < 6000) begin
      b_in_valid = ($urandom_range(0, 1) == 1);
      b_in_sof   = (idx == 0);
      b_in_data  = pix28[idx];
      #2;
      if (b_in_valid && b_in_ready) idx++;
      @(posedge clk); #1;
      guard++;
    end
    b_in_valid = 1'b0; b_in_sof = 1'b0;
    tests++; if (idx != 784) begin fails++; $display("FAIL t3_timeout accepted %0d exp 784", idx); end
    idle(3);
    tests++; if (b_winq.size() != 576) begin fails++; $display("FAIL t3_count got %0d exp 576", b_winq.size()); end
    n = (b_winq.size() < 576) ? b_winq.size() : 576;
    for (int j = 0; j < n; j++) begin
      tests++;
      if (b_winq[j] !== exp28(j)) begin
        fails++;
        $display("FAIL t3_w%0d got %h exp %h", j, b_winq[j], exp28(j));
      end
    end
  endtask

  task automatic test_sof_restart();
    do_reset();
    drive6(0, 0, 14, 1'b1);
    drive6(100, 0, 36, 1'b1);
    idle(3);
    tests++; if (winq.size() != 4) begin fails++; $display("FAIL t4_count got %0d exp 4", winq.size()); end
    if (winq.size() >= 1) begin
      tests++; if (lane(winq[0], 0) !== 16'd100) begin fails++; $display("FAIL t4_w0_l0 got %0d exp 100", lane(winq[0], 0)); end
      tests++; if (lane(winq[0], 24) !== 16'd128) begin fails++; $display("FAIL t4_w0_l24 got %0d exp 128", lane(winq[0], 24)); end
    end
    check_frame6("t4", 100, 0);
    tests++; if (fd_cnt != 1) begin fails++; $display("FAIL t4_fd_count got %0d exp 1", fd_cnt); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    out_ready = 1'b0;
    drive6(0, 0, 29, 1'b1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t5_pending got %b exp 1", out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t5_out_valid got %b exp 0", out_valid); end
    tests++; if (win_data !== '0) begin fails++; $display("FAIL t5_win_data got %h exp 0", win_data); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t5_in_ready got %b exp 1", in_ready); end
    out_ready = 1'b1;
    winq.delete();
    fd_cnt = 0;
    drive6(200, 0, 36, 1'b0);
    idle(3);
    tests++; if (winq.size() != 4) begin fails++; $display("FAIL t5_count got %0d exp 4", winq.size()); end
    check_frame6("t5", 200, 0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive6(0, 0, 36, 1'b1);
    drive6(300, 0, 36, 1'b0);
    idle(3);
    tests++; if (winq.size() != 8) begin fails++; $display("FAIL t6_count got %0d exp 8", winq.size()); end
    check_frame6("t6a", 0, 0);
    check_frame6("t6b", 300, 4);
    tests++; if (fd_cnt != 2) begin fails++; $display("FAIL t6_fd_count got %0d exp 2", fd_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bubbles28();
    test_sof_restart();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
